// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct
// codes, FSM states, ALU operation classes and ALU control codes.
package mc_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  // R-type funct codes the datapath ALU can execute.
  function automatic logic funct_supported(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's aluop class and the funct field to alucontrol.
module mc_aludec
  import mc_controller_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol
);

  // Fixed add/sub for address and branch math, funct lookup for R-type.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: main FSM with memory handshake, sticky
// illegal-instruction trap and retired-instruction counter.
// Handshake: mem_req is held high for the whole access; the access
// completes on the rising edge where mem_req and mem_ready are both 1.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             memwrite,
  output logic             pcen,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic             illegal,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q, state_d;
  aluop_t           aluop;
  logic             pcwrite, branch, bne_br;
  logic             mem_req_raw, memwrite_raw, irwrite_raw, regwrite_raw;
  logic             illegal_q;
  logic [CNT_W-1:0] instret_q;

  // State, trap flag and fetch counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_ILLEGAL) illegal_q <= 1'b1;
      if (state_q == S_FETCH && mem_ready) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Next-state logic and Moore output decode (memory states gated by mem_ready).
  always_comb begin
    state_d      = state_q;
    mem_req_raw  = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    bne_br       = 1'b0;
    alusrca      = 1'b0;
    iord         = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_raw = 1'b1;
        alusrcb     = 2'b01;
        irwrite_raw = mem_ready;
        pcwrite     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_RTYPE:        state_d = funct_supported(funct) ? S_EXECUTE : S_ILLEGAL;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_ADDI:         state_d = S_ADDIEX;
          OP_J:            state_d = S_JUMP;
          default:         state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req_raw = 1'b1;
        iord        = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_raw  = 1'b1;
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = (op == OP_BEQ);
        bne_br  = (op == OP_BNE);
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
  end

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  // Side-effecting strobes are held off combinationally while reset is low.
  assign mem_req   = mem_req_raw  & reset;
  assign memwrite  = memwrite_raw & reset;
  assign irwrite   = irwrite_raw  & reset;
  assign regwrite  = regwrite_raw & reset;
  assign pcen      = (pcwrite | (branch & zero) | (bne_br & ~zero)) & reset;
  assign illegal   = illegal_q;
  assign state_dbg = state_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: table of instruction vectors, randomized
// instruction stream against a per-instruction timing model, and hand
// sequences for reset, stalls, abort and the illegal trap.
module tb_mc_controller;
  import mc_controller_pkg::*;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [5:0]       op = 6'd0;
  logic [5:0]       funct = 6'd0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, memwrite, pcen, irwrite, regwrite;
  logic             alusrca, iord, memtoreg, regdst, illegal;
  logic [1:0]       alusrcb, pcsrc;
  logic [2:0]       alucontrol;
  logic [3:0]       state_dbg;
  logic [CNT_W-1:0] instret;

  int checks = 0;
  int failures = 0;
  int exp_instret = 0;

  mc_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
    .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .alusrca(alusrca),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal),
    .state_dbg(state_dbg), .instret(instret)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_instret = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: per-instruction behaviour from the ISA-level rules
  function automatic bit is_mem(input logic [5:0] o);
    return (o == OP_LW) || (o == OP_SW);
  endfunction

  function automatic int m_cycles(input logic [5:0] o);
    case (o)
      OP_LW:          return 5;
      OP_SW:          return 4;
      OP_RTYPE:       return 4;
      OP_BEQ, OP_BNE: return 3;
      OP_ADDI:        return 4;
      default:        return 3; // j
    endcase
  endfunction

  function automatic int m_pcen(input logic [5:0] o, input logic z);
    int n = 1; // PC+4 at fetch
    if (o == OP_J) n++;
    if (o == OP_BEQ && z) n++;
    if (o == OP_BNE && !z) n++;
    return n;
  endfunction

  function automatic logic [2:0] m_alu(input logic [5:0] o, input logic [5:0] f);
    if (o != OP_RTYPE) return 3'b010;
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // mem_ready schedule: f stalls in fetch, m stalls in the data access,
  // and random (ignored) values wherever no access is pending
  function automatic logic rdy_at(input int c, input int f, input int m, input bit mem, input bit rnd);
    if (c < f) return 1'b0;
    if (c == f) return 1'b1;
    if (mem && c >= f + 3 && c < f + 3 + m) return 1'b0;
    if (mem && c == f + 3 + m) return 1'b1;
    return rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // driver: run one instruction from FETCH back to FETCH, collecting activity
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f_i, input logic z,
                           input int f, input int m, input bit rnd,
                           output int cyc, output int regw, output int memw,
                           output int pcn, output int irw, output logic [2:0] alu,
                           output logic [1:0] wb, output logic [1:0] brs);
    bit done = 0;
    cyc = 0; regw = 0; memw = 0; pcn = 0; irw = 0;
    alu = 3'b010; wb = 2'b00; brs = 2'b00;
    op = o; funct = f_i; zero = z;
    while (!done && cyc < 60) begin
      mem_ready = rdy_at(cyc, f, m, is_mem(o), rnd);
      @(negedge clk);
      if (irwrite) irw++;
      if (regwrite) begin regw++; wb = {regdst, memtoreg}; end
      if (memwrite) memw++;
      if (pcen) pcn++;
      if (state_dbg == S_EXECUTE) alu = alucontrol;
      if (state_dbg == S_BRANCH) brs = pcsrc;
      @(posedge clk); #1;
      cyc++;
      if (irw > 0 && state_dbg == S_FETCH) done = 1;
    end
    exp_instret++;
  endtask

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         f;
    int         m;
    int         cyc;
    int         regw;
    int         memw;
    int         pcn;
    logic [2:0] alu;
    logic [1:0] wb;
    logic [1:0] brs;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int cyc, regw, memw, pcn, irw;
    logic [2:0] alu;
    logic [1:0] wb, brs;
    state_t seq[6];

    tbl[0]  = '{"lw",       OP_LW,    6'h00,  1'b0, 0, 0, 5, 1, 0, 1, 3'b010, 2'b01, 2'b00};
    tbl[1]  = '{"sw_stall", OP_SW,    6'h00,  1'b0, 0, 3, 7, 0, 4, 1, 3'b010, 2'b00, 2'b00};
    tbl[2]  = '{"sub",      OP_RTYPE, FN_SUB, 1'b0, 0, 0, 4, 1, 0, 1, 3'b110, 2'b10, 2'b00};
    tbl[3]  = '{"and_fstl", OP_RTYPE, FN_AND, 1'b0, 2, 0, 6, 1, 0, 1, 3'b000, 2'b10, 2'b00};
    tbl[4]  = '{"or",       OP_RTYPE, FN_OR,  1'b1, 0, 0, 4, 1, 0, 1, 3'b001, 2'b10, 2'b00};
    tbl[5]  = '{"slt",      OP_RTYPE, FN_SLT, 1'b0, 0, 0, 4, 1, 0, 1, 3'b111, 2'b10, 2'b00};
    tbl[6]  = '{"add",      OP_RTYPE, FN_ADD, 1'b0, 0, 0, 4, 1, 0, 1, 3'b010, 2'b10, 2'b00};
    tbl[7]  = '{"beq_t",    OP_BEQ,   6'h00,  1'b1, 0, 0, 3, 0, 0, 2, 3'b010, 2'b00, 2'b01};
    tbl[8]  = '{"beq_nt",   OP_BEQ,   6'h00,  1'b0, 0, 0, 3, 0, 0, 1, 3'b010, 2'b00, 2'b01};
    tbl[9]  = '{"bne_t",    OP_BNE,   6'h00,  1'b0, 0, 0, 3, 0, 0, 2, 3'b010, 2'b00, 2'b01};
    tbl[10] = '{"bne_nt",   OP_BNE,   6'h00,  1'b1, 0, 0, 3, 0, 0, 1, 3'b010, 2'b00, 2'b01};
    tbl[11] = '{"addi",     OP_ADDI,  6'h00,  1'b0, 1, 0, 5, 1, 0, 1, 3'b010, 2'b00, 2'b00};
    tbl[12] = '{"j",        OP_J,     6'h00,  1'b0, 0, 0, 3, 0, 0, 2, 3'b010, 2'b00, 2'b00};
    tbl[13] = '{"lw_stall", OP_LW,    6'h00,  1'b0, 2, 2, 9, 1, 0, 1, 3'b010, 2'b01, 2'b00};

    // reset state
    @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'(S_FETCH));
    check("rst_strobes", {27'd0, mem_req, memwrite, pcen, irwrite, regwrite}, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_alusrcb", 32'(alusrcb), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;

    // lw state walk with mem_ready tied high
    seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_FETCH};
    op = OP_LW; funct = 6'd0; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("lw_state%0d", i), 32'(state_dbg), 32'(seq[i]));
      check($sformatf("lw_wb%0d", i), {30'd0, regwrite, memtoreg}, (i == 4) ? 32'd3 : 32'd0);
      if (i == 1) check("lw_instret", instret, 32'd1);
      @(posedge clk); #1;
    end
    apply_reset();

    // table-driven vectors
    for (int i = 0; i < 14; i++) begin
      run_instr(tbl[i].op, tbl[i].funct, tbl[i].zero, tbl[i].f, tbl[i].m, 1'b0,
                cyc, regw, memw, pcn, irw, alu, wb, brs);
      check({tbl[i].name, "_cyc"}, cyc, tbl[i].cyc);
      check({tbl[i].name, "_regw"}, regw, tbl[i].regw);
      check({tbl[i].name, "_memw"}, memw, tbl[i].memw);
      check({tbl[i].name, "_pcen"}, pcn, tbl[i].pcn);
      check({tbl[i].name, "_irw"}, irw, 1);
      check({tbl[i].name, "_alu"}, 32'(alu), 32'(tbl[i].alu));
      check({tbl[i].name, "_wb"}, 32'(wb), 32'(tbl[i].wb));
      check({tbl[i].name, "_pcsrc"}, 32'(brs), 32'(tbl[i].brs));
      check({tbl[i].name, "_instret"}, instret, exp_instret);
    end

    // randomized instruction stream against the model
    begin
      logic [5:0] ops[11] = '{OP_LW, OP_SW, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE,
                              OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
      logic [5:0] fns[11] = '{6'h00, 6'h00, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT,
                              6'h00, 6'h00, 6'h00, 6'h00};
      for (int n = 0; n < 40; n++) begin
        int k = $urandom_range(0, 10);
        int f = $urandom_range(0, 3);
        int m = $urandom_range(0, 3);
        logic z = 1'($urandom_range(0, 1));
        int ecyc = m_cycles(ops[k]) + f + (is_mem(ops[k]) ? m : 0);
        run_instr(ops[k], fns[k], z, f, m, 1'b1, cyc, regw, memw, pcn, irw, alu, wb, brs);
        check($sformatf("rnd%0d_cyc", n), cyc, ecyc);
        check($sformatf("rnd%0d_regw", n), regw,
              (ops[k] == OP_LW || ops[k] == OP_RTYPE || ops[k] == OP_ADDI) ? 1 : 0);
        check($sformatf("rnd%0d_memw", n), memw, (ops[k] == OP_SW) ? m + 1 : 0);
        check($sformatf("rnd%0d_pcen", n), pcn, m_pcen(ops[k], z));
        check($sformatf("rnd%0d_alu", n), 32'(alu), 32'(m_alu(ops[k], fns[k])));
        check($sformatf("rnd%0d_instret", n), instret, exp_instret);
      end
    end

    // reset in MEMWR while waiting: strobes drop immediately
    apply_reset();
    op = OP_SW; funct = 6'd0; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    check("abort_pre_state", 32'(state_dbg), 32'(S_MEMWR));
    check("abort_pre_memw", 32'(memwrite), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_memw", {29'd0, memwrite, mem_req, regwrite}, 32'd0);
    check("abort_state", 32'(state_dbg), 32'(S_FETCH));
    check("abort_instret", instret, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_instret = 0;

    // illegal trap: bad opcode, then bad funct
    for (int t = 0; t < 2; t++) begin
      op = (t == 0) ? 6'b111111 : OP_RTYPE;
      funct = (t == 0) ? 6'd0 : 6'b000111;
      mem_ready = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      for (int c = 0; c < 4; c++) begin
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check($sformatf("ill%0d_state%0d", t, c), 32'(state_dbg), 32'(S_ILLEGAL));
        check($sformatf("ill%0d_flag%0d", t, c), 32'(illegal), 32'd1);
        check($sformatf("ill%0d_strb%0d", t, c), {27'd0, mem_req, memwrite, pcen, irwrite, regwrite}, 32'd0);
        @(posedge clk); #1;
      end
      check($sformatf("ill%0d_instret", t), instret, 32'd1);
      apply_reset();
      @(negedge clk);
      check($sformatf("ill%0d_clr", t), 32'(illegal), 32'd0);
      check($sformatf("ill%0d_rst_state", t), 32'(state_dbg), 32'(S_FETCH));
      check($sformatf("ill%0d_rst_cnt", t), instret, 32'd0);
      @(posedge clk); #1;
      apply_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
